cond_flags: RTL and testbench

//  Processor status-flag register. Produces the condition inputs (in2..in7) that
//  the branch-condition multiplexer selects from.
//  - Captures ALU Z/C/N/V flags on a flag-write strobe.
//  - Keeps a sticky overflow bit.
//  - Holds a DEPTH-entry LIFO so the interrupt/call path can save and restore flags.
//  - Sits between the ALU flag outputs and the branch-condition mux.

---
 rtl/cond_flags_if.sv | 43 ++++
 rtl/cond_flags.sv | 92 +++++++++
 tb/tb_cond_flags.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cond_flags_if.sv
`default_nettype none
// ============================================================================
//  Module      : cond_flags_if
//  Description : ALU-flag / stack-control bundle between the datapath and the
//                status-flag register, plus the decoded branch conditions.
//  Revision    : 1.0  initial release
// ============================================================================
interface cond_flags_if;
    logic       alu_zero;
    logic       alu_carry;
    logic       alu_neg;
    logic       alu_ovf;
    logic       flag_we;
    logic       push;
    logic       pop;
    logic       clr_sticky;
    logic [3:0] flags;
    logic       in2;
    logic       in3;
    logic       in4;
    logic       in5;
    logic       in6;
    logic       in7;
    logic       sticky_v;
    logic       stk_full;
    logic       stk_empty;
    logic       stk_err;

    modport master (
        output alu_zero, alu_carry, alu_neg, alu_ovf,
        output flag_we, push, pop, clr_sticky,
        input  flags, in2, in3, in4, in5, in6, in7,
        input  sticky_v, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  alu_zero, alu_carry, alu_neg, alu_ovf,
        input  flag_we, push, pop, clr_sticky,
        output flags, in2, in3, in4, in5, in6, in7,
        output sticky_v, stk_full, stk_empty, stk_err
    );
endinterface
`default_nettype wire

// File: rtl/cond_flags.sv
`default_nettype none
// ============================================================================
//  Module      : cond_flags
//  Description : Processor status-flag register with sticky overflow and a
//                DEPTH-entry save/restore LIFO feeding the branch-condition mux.
//  Revision    : 1.0  initial release
// ============================================================================
module cond_flags #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 3
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    cond_flags_if.slave bus
);
    localparam int c_slots = 1 << PTR_W;

    logic [3:0]       r_flags;
    logic             r_sticky;
    logic             r_err;
    logic [PTR_W-1:0] r_sp;
    logic [3:0]       r_stack [c_slots];

    logic [3:0]       w_alu;
    logic             w_full;
    logic             w_empty;
    logic             w_load;
    logic             w_do_pop;
    logic             w_do_push;
    logic             w_err;
    logic [PTR_W-1:0] w_sp_dec;

    assign w_alu     = {bus.alu_ovf, bus.alu_neg, bus.alu_carry, bus.alu_zero};
    assign w_full    = (r_sp == PTR_W'(DEPTH));
    assign w_empty   = (r_sp == '0);
    assign w_sp_dec  = r_sp - PTR_W'(1);

    // Any asserted pop (legal or not) blocks the ALU load; push alone does not.
    assign w_load    = bus.flag_we & ~bus.pop;
    assign w_do_pop  = bus.pop  & ~bus.push & ~w_empty;
    assign w_do_push = bus.push & ~bus.pop  & ~w_full;
    assign w_err     = (bus.push & bus.pop)
                     | (bus.pop  & ~bus.push & w_empty)
                     | (bus.push & ~bus.pop  & w_full);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags  <= 4'h0;
            r_sticky <= 1'b0;
            r_err    <= 1'b0;
            r_sp     <= '0;
        end else begin
            r_err <= w_err;
            if (w_do_pop) begin
                r_flags <= r_stack[w_sp_dec];
                r_sp    <= w_sp_dec;
            end else begin
                if (w_do_push) begin
                    r_sp <= r_sp + PTR_W'(1);
                end
                if (w_load) begin
                    r_flags <= w_alu;
                end
            end
            if (w_load && bus.alu_ovf) begin
                r_sticky <= 1'b1;
            end else if (bus.clr_sticky) begin
                r_sticky <= 1'b0;
            end
        end
    end

    // Storage needs no reset: the pointer guards every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_stack[r_sp] <= r_flags;
        end
    end

    assign bus.flags     = r_flags;
    assign bus.in2       = r_flags[0];
    assign bus.in3       = ~r_flags[0];
    assign bus.in4       = r_flags[1];
    assign bus.in5       = ~r_flags[1];
    assign bus.in6       = r_flags[2];
    assign bus.in7       = r_flags[3];
    assign bus.sticky_v  = r_sticky;
    assign bus.stk_full  = w_full;
    assign bus.stk_empty = w_empty;
    assign bus.stk_err   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_cond_flags.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cond_flags
//  Description : Self-checking bench for cond_flags: directed and random ops
//                against a queue-based reference model with a scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cond_flags;
    localparam int DEPTH = 4;

    typedef logic [13:0] obs_t;
    typedef struct {
        obs_t  v;
        string tag;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    cond_flags_if bus();

    cond_flags #(.DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] m_flags  = 4'h0;
    logic       m_sticky = 1'b0;
    logic [3:0] m_stack[$];

    // {flags, in2..in7, sticky_v, stk_err, stk_full, stk_empty}
    function automatic obs_t pack(logic [3:0] f, logic s, logic e, int depth);
        return {f, f[0], !f[0], f[1], !f[1], f[2], f[3], s, e,
                depth == DEPTH, depth == 0};
    endfunction

    function automatic obs_t observe();
        return {bus.flags, bus.in2, bus.in3, bus.in4, bus.in5, bus.in6, bus.in7,
                bus.sticky_v, bus.stk_err, bus.stk_full, bus.stk_empty};
    endfunction

    task automatic check(string name, obs_t act, obs_t want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b (flags,in2-7,sticky,err,full,empty)",
                     name, act, want);
        end
    endtask

    task automatic step(input logic fw, input logic [3:0] alu, input logic ps,
                        input logic pp, input logic clr, input string tag);
        logic err;
        exp_t e;
        @(negedge clk);
        {bus.alu_ovf, bus.alu_neg, bus.alu_carry, bus.alu_zero} = alu;
        bus.flag_we    = fw;
        bus.push       = ps;
        bus.pop        = pp;
        bus.clr_sticky = clr;
        err = 1'b0;
        if (ps && pp) begin
            err = 1'b1;
        end else if (pp) begin
            if (m_stack.size() > 0) m_flags = m_stack.pop_back();
            else                    err = 1'b1;
        end else begin
            if (ps) begin
                if (m_stack.size() < DEPTH) m_stack.push_back(m_flags);
                else                        err = 1'b1;
            end
            if (fw) m_flags = alu;
        end
        if (fw && !pp && alu[3]) m_sticky = 1'b1;
        else if (clr)            m_sticky = 1'b0;
        e.v   = pack(m_flags, m_sticky, err, m_stack.size());
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, "idle");
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.tag, observe(), e.v);
            end
        end
    end

    initial begin : stim
        bus.alu_zero = 0; bus.alu_carry = 0; bus.alu_neg = 0; bus.alu_ovf = 0;
        bus.flag_we = 0; bus.push = 0; bus.pop = 0; bus.clr_sticky = 0;
        #2;
        check("reset_state", observe(), pack(4'h0, 1'b0, 1'b0, 0));
        @(negedge clk);
        reset_n = 1'b1;

        // Capture {V,N,C,Z} = 1011
        step(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, "capture");
        // LIFO fill, overflow, drain, underflow
        step(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, "load1");
        step(1'b1, 4'h2, 1'b1, 1'b0, 1'b0, "push1");
        step(1'b1, 4'h4, 1'b1, 1'b0, 1'b0, "push2");
        step(1'b1, 4'h8, 1'b1, 1'b0, 1'b0, "push4");
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, "push8_full");
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, "push_overflow");
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, "pop_restore");
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, "pop_underflow");
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, "err_clears");
        // push together with flag_we saves the pre-update value
        step(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, "load3");
        step(1'b1, 4'hC, 1'b1, 1'b0, 1'b0, "push_and_load");
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, "pop_back3");
        // pop beats ALU load; push&pop together is an error with no change
        step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, "load5");
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, "push5");
        step(1'b1, 4'h6, 1'b0, 1'b0, 1'b0, "load6");
        step(1'b1, 4'hA, 1'b0, 1'b1, 1'b0, "pop_over_load");
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, "push_again");
        step(1'b1, 4'h7, 1'b1, 1'b1, 1'b0, "push_and_pop");
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, "err_one_cycle");
        // sticky: set beats clear, then clear alone
        step(1'b1, 4'h8, 1'b0, 1'b0, 1'b1, "sticky_set_wins");
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, "sticky_clear");
        drain();

        // Asynchronous reset mid-cycle with flags=F and a non-empty stack
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, "push_pre_reset");
        step(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, "loadF");
        drain();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset", observe(), pack(4'h0, 1'b0, 1'b0, 0));
        m_flags  = 4'h0;
        m_sticky = 1'b0;
        m_stack.delete();
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom),
                 $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 10, "random");
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
